// File: rtl/logic_ram_loader_pkg.sv
// Shared types and defaults for the logic RAM loader slice.
package logic_ram_pkg;

    // Sequencer states: wait for Start, take the beats, sweep the reads, report.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Geometry of the RAM stage this loader feeds.
    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Values every register returns to on Reset.
    localparam logic        RST_WE          = 1'b0;
    localparam logic        RST_IN_READY    = 1'b0;
    localparam logic        RST_SWEEP_VALID = 1'b0;
    localparam logic        RST_BUSY        = 1'b0;
    localparam logic        RST_DONE        = 1'b0;
    localparam int unsigned RST_ADDR        = 0;
    localparam int unsigned RST_DATA        = 0;

endpackage

// File: rtl/logic_ram_loader_if.sv
// Stream, command and RAM-facing signals of the loader grouped as one bundle.
interface logic_ram_loader_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) ();

    logic                  Start;
    logic [DATA_WIDTH-1:0] StartOp;
    logic                  InValid;
    logic [DATA_WIDTH-1:0] InData;
    logic                  InReady;
    logic                  WE;
    logic [ADDR_WIDTH-1:0] WriteAddr;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [ADDR_WIDTH-1:0] ReadAddr;
    logic [DATA_WIDTH-1:0] OpData;
    logic                  SweepValid;
    logic                  Busy;
    logic                  Done;

    // Upstream side: issues commands and data, observes the loader.
    modport master (
        output Start, StartOp, InValid, InData,
        input  InReady, WE, WriteAddr, WriteData, ReadAddr, OpData,
               SweepValid, Busy, Done
    );

    // Loader side.
    modport slave (
        input  Start, StartOp, InValid, InData,
        output InReady, WE, WriteAddr, WriteData, ReadAddr, OpData,
               SweepValid, Busy, Done
    );

endinterface

// File: rtl/logic_ram_loader_wrap_counter.sv
// Modulo-2^WIDTH counter with synchronous clear taking priority over increment.
module wrap_counter #(
    parameter int WIDTH = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count register; natural binary overflow provides the wrap.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/logic_ram_loader.sv
// Loads DEPTH stream beats into the logic RAM, then sweeps every read address.
module logic_ram_loader
    import logic_ram_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic              Clock,
    input logic              Reset,
    logic_ram_loader_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q;
    logic                  inReady_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] writeAddr_q;
    logic [DATA_WIDTH-1:0] writeData_q;
    logic [DATA_WIDTH-1:0] opData_q;
    logic                  sweepValid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [ADDR_WIDTH-1:0] loadCount;
    logic [ADDR_WIDTH-1:0] sweepIdx;
    logic                  startAccept;
    logic                  beatAccept;
    logic                  lastBeat;
    logic                  loadClear;
    logic                  sweepClear;
    logic                  sweepInc;

    // Counter controls decoded from the current state and the inputs.
    always_comb begin
        startAccept = 1'b0;
        beatAccept  = 1'b0;
        lastBeat    = 1'b0;
        sweepInc    = 1'b0;
        if (state_q == IDLE) begin
            startAccept = bus.Start;
        end
        if (state_q == LOAD) begin
            beatAccept = bus.InValid;
        end
        if (beatAccept && (loadCount == LAST_ADDR)) begin
            lastBeat = 1'b1;
        end
        if ((state_q == SWEEP) && (sweepIdx != LAST_ADDR)) begin
            sweepInc = 1'b1;
        end
        loadClear  = startAccept;
        sweepClear = lastBeat;
    end

    wrap_counter #(.WIDTH(ADDR_WIDTH)) loadCounter (
        .Clock (Clock),
        .Reset (Reset),
        .clear (loadClear),
        .inc   (beatAccept),
        .count (loadCount)
    );

    // The sweep index stops at the last address so ReadAddr holds it afterwards.
    wrap_counter #(.WIDTH(ADDR_WIDTH)) sweepCounter (
        .Clock (Clock),
        .Reset (Reset),
        .clear (sweepClear),
        .inc   (sweepInc),
        .count (sweepIdx)
    );

    // Sequencer with every output registered alongside the state transition.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            inReady_q    <= RST_IN_READY;
            we_q         <= RST_WE;
            writeAddr_q  <= ADDR_WIDTH'(RST_ADDR);
            writeData_q  <= DATA_WIDTH'(RST_DATA);
            opData_q     <= DATA_WIDTH'(RST_DATA);
            sweepValid_q <= RST_SWEEP_VALID;
            busy_q       <= RST_BUSY;
            done_q       <= RST_DONE;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        state_q   <= LOAD;
                        opData_q  <= bus.StartOp;
                        inReady_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.InValid) begin
                        we_q        <= 1'b1;
                        writeAddr_q <= loadCount;
                        writeData_q <= bus.InData;
                        if (loadCount == LAST_ADDR) begin
                            state_q      <= SWEEP;
                            inReady_q    <= 1'b0;
                            sweepValid_q <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (sweepIdx == LAST_ADDR) begin
                        state_q      <= DONE;
                        sweepValid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.InReady    = inReady_q;
    assign bus.WE         = we_q;
    assign bus.WriteAddr  = writeAddr_q;
    assign bus.WriteData  = writeData_q;
    assign bus.ReadAddr   = sweepIdx;
    assign bus.OpData     = opData_q;
    assign bus.SweepValid = sweepValid_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;

endmodule

// File: tb/tb_logic_ram_loader.sv
// Directed bench for logic_ram_loader: cycle tables plus stall, ignored-Start and abort runs.
module tb_logic_ram_loader;

    typedef struct packed {
        logic       inReady;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [7:0] op;
        logic       sv;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [7:0] op;
        logic       valid;
        logic [7:0] data;
        outs_t      exp;
    } vec_t;

    logic  Clock;
    logic  Reset;
    int    testsRun;
    int    testsFailed;
    vec_t  tbl [21];
    int    wrCyc [$];
    int    wrAddr [$];
    int    wrData [$];

    logic_ram_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    logic_ram_loader #(.DEPTH(4), .ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic vec_t mk(int rst, int start, int op, int valid, int data,
                                int ir, int we, int wa, int wd, int ra, int opd,
                                int sv, int busy, int done);
        vec_t v;
        v.rst         = 1'(rst);
        v.start       = 1'(start);
        v.op          = 8'(op);
        v.valid       = 1'(valid);
        v.data        = 8'(data);
        v.exp.inReady = 1'(ir);
        v.exp.we      = 1'(we);
        v.exp.wa      = 2'(wa);
        v.exp.wd      = 8'(wd);
        v.exp.ra      = 2'(ra);
        v.exp.op      = 8'(opd);
        v.exp.sv      = 1'(sv);
        v.exp.busy    = 1'(busy);
        v.exp.done    = 1'(done);
        return v;
    endfunction

    function automatic outs_t getOuts();
        outs_t o;
        o.inReady = bus.InReady;
        o.we      = bus.WE;
        o.wa      = bus.WriteAddr;
        o.wd      = bus.WriteData;
        o.ra      = bus.ReadAddr;
        o.op      = bus.OpData;
        o.sv      = bus.SweepValid;
        o.busy    = bus.Busy;
        o.done    = bus.Done;
        return o;
    endfunction

    task automatic applyStimulus(input int rst, input int start, input int op,
                                 input int valid, input int data);
        Reset       = 1'(rst);
        bus.Start   = 1'(start);
        bus.StartOp = 8'(op);
        bus.InValid = 1'(valid);
        bus.InData  = 8'(data);
    endtask

    task automatic checkOutput(input outs_t exp, input string name);
        outs_t act;
        act = getOuts();
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got ir=%0b we=%0b wa=%0d wd=%0d ra=%0d op=%0d sv=%0b busy=%0b done=%0b, expected ir=%0b we=%0b wa=%0d wd=%0d ra=%0d op=%0d sv=%0b busy=%0b done=%0b",
                     name, act.inReady, act.we, act.wa, act.wd, act.ra, act.op, act.sv, act.busy, act.done,
                     exp.inReady, exp.we, exp.wa, exp.wd, exp.ra, exp.op, exp.sv, exp.busy, exp.done);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int doneCnt;
        int doneCyc;
        int badOp;
        int busyLate;
        int expCyc [4];
        int expAddr [4];
        int expData [4];

        testsRun    = 0;
        testsFailed = 0;
        applyStimulus(1, 0, 0, 0, 0);

        // Nominal run (rows 0-9) followed by back-to-back run started in row 10.
        //           rst st op   v  data  ir we wa wd   ra op   sv bz dn
        tbl[0]  = mk(0, 1, 240, 0, 0,     0, 0, 0, 0,   0, 0,   0, 0, 0);
        tbl[1]  = mk(0, 0, 0,   1, 102,   1, 0, 0, 0,   0, 240, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0,   1, 170,   1, 1, 0, 102, 0, 240, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0,   1, 85,    1, 1, 1, 170, 0, 240, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0,   1, 255,   1, 1, 2, 85,  0, 240, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0,   1, 170,   0, 1, 3, 255, 0, 240, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0,   1, 170,   0, 0, 3, 255, 1, 240, 1, 1, 0);
        tbl[7]  = mk(0, 0, 0,   1, 170,   0, 0, 3, 255, 2, 240, 1, 1, 0);
        tbl[8]  = mk(0, 0, 0,   1, 170,   0, 0, 3, 255, 3, 240, 1, 1, 0);
        tbl[9]  = mk(0, 0, 0,   1, 170,   0, 0, 3, 255, 3, 240, 0, 0, 1);
        tbl[10] = mk(0, 1, 15,  0, 0,     0, 0, 3, 255, 3, 240, 0, 0, 0);
        tbl[11] = mk(0, 0, 0,   1, 1,     1, 0, 3, 255, 3, 15,  0, 1, 0);
        tbl[12] = mk(0, 0, 0,   1, 2,     1, 1, 0, 1,   3, 15,  0, 1, 0);
        tbl[13] = mk(0, 0, 0,   1, 3,     1, 1, 1, 2,   3, 15,  0, 1, 0);
        tbl[14] = mk(0, 0, 0,   1, 4,     1, 1, 2, 3,   3, 15,  0, 1, 0);
        tbl[15] = mk(0, 0, 0,   0, 0,     0, 1, 3, 4,   0, 15,  1, 1, 0);
        tbl[16] = mk(0, 0, 0,   0, 0,     0, 0, 3, 4,   1, 15,  1, 1, 0);
        tbl[17] = mk(0, 0, 0,   0, 0,     0, 0, 3, 4,   2, 15,  1, 1, 0);
        tbl[18] = mk(0, 0, 0,   0, 0,     0, 0, 3, 4,   3, 15,  1, 1, 0);
        tbl[19] = mk(0, 0, 0,   0, 0,     0, 0, 3, 4,   3, 15,  0, 0, 1);
        tbl[20] = mk(0, 0, 0,   0, 0,     0, 0, 3, 4,   3, 15,  0, 0, 0);

        repeat (2) @(posedge Clock);
        #1;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].start, tbl[i].op, tbl[i].valid, tbl[i].data);
            @(negedge Clock);
            checkOutput(tbl[i].exp, $sformatf("table cycle %0d", i));
            nextCycle();
        end

        // Stalled stream: two idle cycles between the first and second beat.
        expCyc  = '{2, 5, 6, 7};
        expAddr = '{0, 1, 2, 3};
        expData = '{102, 170, 85, 255};
        doneCnt = 0;
        doneCyc = -1;
        applyStimulus(0, 1, 240, 0, 0);
        nextCycle();
        for (int k = 1; k <= 20; k++) begin
            case (k)
                1:       applyStimulus(0, 0, 0, 1, 102);
                4:       applyStimulus(0, 0, 0, 1, 170);
                5:       applyStimulus(0, 0, 0, 1, 85);
                6:       applyStimulus(0, 0, 0, 1, 255);
                default: applyStimulus(0, 0, 0, 0, 0);
            endcase
            @(negedge Clock);
            if (bus.WE) begin
                wrCyc.push_back(k);
                wrAddr.push_back(int'(bus.WriteAddr));
                wrData.push_back(int'(bus.WriteData));
            end
            if (bus.Done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = k;
            end
            nextCycle();
        end
        checkValue("stall write count", wrCyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkValue($sformatf("stall write %0d cycle", i), (i < wrCyc.size()) ? wrCyc[i] : -1, expCyc[i]);
            checkValue($sformatf("stall write %0d addr", i), (i < wrAddr.size()) ? wrAddr[i] : -1, expAddr[i]);
            checkValue($sformatf("stall write %0d data", i), (i < wrData.size()) ? wrData[i] : -1, expData[i]);
        end
        checkValue("stall done cycle", doneCyc, 11);
        checkValue("stall done count", doneCnt, 1);

        // Start pulses with a different operand in LOAD, SWEEP and DONE.
        doneCnt  = 0;
        doneCyc  = -1;
        badOp    = 0;
        busyLate = 0;
        applyStimulus(0, 1, 240, 0, 0);
        nextCycle();
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(0, (k == 2 || k == 6 || k == 9) ? 1 : 0, 80,
                          (k <= 4) ? 1 : 0, k * 10);
            @(negedge Clock);
            if (bus.OpData != 8'd240) badOp++;
            if (bus.Done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = k;
            end
            if (k >= 10 && bus.Busy) busyLate++;
            nextCycle();
        end
        checkValue("ignored start opdata changes", badOp, 0);
        checkValue("ignored start done count", doneCnt, 1);
        checkValue("ignored start done cycle", doneCyc, 9);
        checkValue("ignored start busy after done", busyLate, 0);

        // Reset in cycle 3 with a beat pending, then a fresh run with operand 80.
        applyStimulus(0, 1, 240, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 11);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 22);
        nextCycle();
        applyStimulus(1, 0, 0, 1, 33);
        nextCycle();
        applyStimulus(0, 1, 80, 0, 0);
        @(negedge Clock);
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).exp, "abort reset values");
        nextCycle();
        applyStimulus(0, 0, 0, 1, 44);
        @(negedge Clock);
        checkOutput(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 80, 0, 1, 0).exp, "restart load entry");
        nextCycle();
        applyStimulus(0, 0, 0, 1, 55);
        @(negedge Clock);
        checkOutput(mk(0, 0, 0, 0, 0, 1, 1, 0, 44, 0, 80, 0, 1, 0).exp, "restart first write");
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge Clock);
        checkOutput(mk(0, 0, 0, 0, 0, 1, 1, 1, 55, 0, 80, 0, 1, 0).exp, "restart second write");
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
